// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hack_pkg
// Purpose  : Shared types, address map and region decode for the Hack memory
//            responder.
//            - mem_state_e : loader phase (LOAD, RELEASE, RUN)
//            - region_e    : data-bus target (RAM, SCREEN, KBD, NONE)
//            - decode_region() maps a data address onto a region
// Revision : 1.0  initial release
// ============================================================================
package hack_pkg;

    localparam int unsigned     c_RAM_DEPTH    = 16384;
    localparam logic [15:0]     c_SCREEN_BASE  = 16'h4000;
    localparam int unsigned     c_SCREEN_DEPTH = 256;
    localparam logic [15:0]     c_KBD_ADDR     = 16'h6000;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        RAM    = 2'd0,
        SCREEN = 2'd1,
        KBD    = 2'd2,
        NONE   = 2'd3
    } region_e;

    // All bounds are passed in so the decode follows the instantiating
    // module's parameters rather than the package defaults.
    function automatic region_e decode_region(
        input logic [31:0] addr,
        input logic [31:0] ram_depth,
        input logic [31:0] screen_base,
        input logic [31:0] screen_depth,
        input logic [31:0] kbd_addr
    );
        region_e r;
        r = NONE;
        if (addr < ram_depth) begin
            r = RAM;
        end else if ((addr >= screen_base) && (addr < screen_base + screen_depth)) begin
            r = SCREEN;
        end else if (addr == kbd_addr) begin
            r = KBD;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hack_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : hack_rom_loader
// Purpose  : Streaming program loader. Accepts words into the instruction ROM
//            while the CPU is held in reset, spends one RELEASE cycle, then
//            lets the CPU run until the next reset.
// Ports    : clk, rst          clock / synchronous active-high reset
//            load_valid        word offered by the loader
//            load_last         offered word is the final one
//            state             current loader phase
//            ptr               ROM write address
//            load_ready        block accepts a word this cycle
//            cpu_rst_out       CPU reset (high until RUN)
//            rom_we            ROM write strobe for rom[ptr]
// Revision : 1.0  initial release
// ============================================================================
module hack_rom_loader
    import hack_pkg::*;
#(
    parameter int ROM_DEPTH = 64,
    parameter int PTR_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic             load_last,
    output mem_state_e       state,
    output logic [PTR_W-1:0] ptr,
    output logic             load_ready,
    output logic             cpu_rst_out,
    output logic             rom_we
);

    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(ROM_DEPTH - 1);

    mem_state_e       r_state;
    mem_state_e       w_next_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_next_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        load_ready   = 1'b0;
        cpu_rst_out  = 1'b1;
        rom_we       = 1'b0;
        case (r_state)
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    rom_we = 1'b1;
                    // The pointer is only advanced while more words may
                    // follow, so it never wraps past the last ROM entry.
                    if (load_last || (r_ptr == c_PTR_LAST)) begin
                        w_next_state = RELEASE;
                    end else begin
                        w_next_ptr = r_ptr + 1'b1;
                    end
                end
            end
            RELEASE: begin
                w_next_state = RUN;
            end
            RUN: begin
                cpu_rst_out = 1'b0;
            end
            default: begin
                w_next_state = LOAD;
            end
        endcase
    end

    assign state = r_state;
    assign ptr   = r_ptr;

endmodule
`default_nettype wire

// File: rtl/hack_memory.sv
`default_nettype none
// ============================================================================
// Module   : hack_memory
// Purpose  : Memory-side responder for the Hack CPU bus. Holds the
//            instruction ROM (filled by a streaming loader), data RAM,
//            screen RAM and a memory-mapped keyboard register.
// Ports    : clk, rst          clock / synchronous active-high reset
//            pc_in             instruction fetch address
//            instruction_out   rom[pc_in] in RUN, else 0
//            address_in        data address
//            write_in          data write enable (honoured in RUN only)
//            data_in           write data
//            data_out          zero-latency read data
//            keyboard_in       keycode, registered every cycle
//            load_valid/ready/data/last  program load stream
//            cpu_rst_out       drive to the CPU reset
// Revision : 1.0  initial release
// ============================================================================
module hack_memory
    import hack_pkg::*;
#(
    parameter int                      DATA_WIDTH    = 16,
    parameter int                      ADDRESS_WIDTH = 16,
    parameter int                      INST_WIDTH    = 16,
    parameter int                      ROM_DEPTH     = 64,
    parameter int                      RAM_DEPTH     = c_RAM_DEPTH,
    parameter logic [ADDRESS_WIDTH-1:0] SCREEN_BASE  = c_SCREEN_BASE,
    parameter int                      SCREEN_DEPTH  = c_SCREEN_DEPTH,
    parameter logic [ADDRESS_WIDTH-1:0] KBD_ADDR     = c_KBD_ADDR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] pc_in,
    output logic [INST_WIDTH-1:0]    instruction_out,
    input  logic [ADDRESS_WIDTH-1:0] address_in,
    input  logic                     write_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    input  logic [DATA_WIDTH-1:0]    keyboard_in,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [INST_WIDTH-1:0]    load_data,
    input  logic                     load_last,
    output logic                     cpu_rst_out
);

    localparam int c_ROM_AW = $clog2(ROM_DEPTH);
    localparam int c_RAM_AW = $clog2(RAM_DEPTH);
    localparam int c_SCR_AW = $clog2(SCREEN_DEPTH);

    logic [INST_WIDTH-1:0] r_rom    [ROM_DEPTH];
    logic [DATA_WIDTH-1:0] r_ram    [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_screen [SCREEN_DEPTH];
    logic [DATA_WIDTH-1:0] r_kbd;

    mem_state_e            w_state;
    logic [c_ROM_AW-1:0]   w_load_ptr;
    logic                  w_rom_we;

    region_e                            w_region;
    logic [c_RAM_AW-1:0]                w_ram_idx;
    logic [ADDRESS_WIDTH-1:0]           w_scr_off;
    logic [c_SCR_AW-1:0]                w_scr_idx;
    logic [ADDRESS_WIDTH-c_SCR_AW-1:0]  w_unused_scr_hi;
    logic                               w_pc_in_rom;
    logic                               w_wr_en;

    hack_rom_loader #(
        .ROM_DEPTH (ROM_DEPTH),
        .PTR_W     (c_ROM_AW)
    ) u_loader (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_last   (load_last),
        .state       (w_state),
        .ptr         (w_load_ptr),
        .load_ready  (load_ready),
        .cpu_rst_out (cpu_rst_out),
        .rom_we      (w_rom_we)
    );

    // ---------------------------------------------------------------- decode
    assign w_region = decode_region(32'(address_in), 32'(RAM_DEPTH),
                                    32'(SCREEN_BASE), 32'(SCREEN_DEPTH),
                                    32'(KBD_ADDR));

    assign w_ram_idx       = address_in[c_RAM_AW-1:0];
    // Offset relative to the screen base; only the low bits index the
    // array, the region decode already guarantees the high bits are zero.
    assign w_scr_off       = address_in - SCREEN_BASE;
    assign w_scr_idx       = w_scr_off[c_SCR_AW-1:0];
    assign w_unused_scr_hi = w_scr_off[ADDRESS_WIDTH-1:c_SCR_AW];

    assign w_pc_in_rom = (pc_in < ADDRESS_WIDTH'(ROM_DEPTH));
    assign w_wr_en     = write_in && (w_state == RUN);

    // ------------------------------------------------------------ storage
    always_ff @(posedge clk) begin
        if (w_rom_we) begin
            r_rom[w_load_ptr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && (w_region == RAM)) begin
            r_ram[w_ram_idx] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && (w_region == SCREEN)) begin
            r_screen[w_scr_idx] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kbd <= '0;
        end else begin
            r_kbd <= keyboard_in;
        end
    end

    // -------------------------------------------------------------- reads
    // Reads are asynchronous so a same-cycle write is seen only after the
    // clock edge that commits it.
    always_comb begin
        instruction_out = '0;
        if ((w_state == RUN) && w_pc_in_rom) begin
            instruction_out = r_rom[pc_in[c_ROM_AW-1:0]];
        end
    end

    always_comb begin
        data_out = '0;
        case (w_region)
            RAM:     data_out = r_ram[w_ram_idx];
            SCREEN:  data_out = r_screen[w_scr_idx];
            KBD:     data_out = r_kbd;
            default: data_out = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_hack_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_memory
// Purpose  : Self-checking bench for hack_memory. A behavioural model tracks
//            the program image, the data address space and the keyboard
//            register; directed and randomised steps are compared against it.
// Revision : 1.0  initial release
// ============================================================================
module tb_hack_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_in;
    logic [15:0] instruction_out;
    logic [15:0] address_in;
    logic        write_in;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [15:0] keyboard_in;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        load_last;
    logic        cpu_rst_out;

    always #5 clk = ~clk;

    hack_memory dut (
        .clk             (clk),
        .rst             (rst),
        .pc_in           (pc_in),
        .instruction_out (instruction_out),
        .address_in      (address_in),
        .write_in        (write_in),
        .data_in         (data_in),
        .data_out        (data_out),
        .keyboard_in     (keyboard_in),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_data       (load_data),
        .load_last       (load_last),
        .cpu_rst_out     (cpu_rst_out)
    );

    // ------------------------------------------------------------ model
    localparam int PH_LOADING = 0;
    localparam int PH_HANDOFF = 1;
    localparam int PH_RUNNING = 2;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          phase    = PH_LOADING;
    int          words_in = 0;
    logic [15:0] m_rom [64];
    logic [15:0] m_data [logic [15:0]];
    logic [15:0] m_kbd = 16'h0;
    logic [15:0] prog1 [6];
    logic [15:0] w0, w1, w2;

    function automatic bit writable(input logic [15:0] a);
        // RAM 0000..3FFF and screen 4000..40FF form one contiguous block.
        return a < 16'h4100;
    endfunction

    // Applies the current inputs to the model, then advances one clock.
    task automatic tick();
        if (rst) begin
            phase    = PH_LOADING;
            words_in = 0;
        end else if (phase == PH_LOADING) begin
            if (load_valid) begin
                m_rom[words_in] = load_data;
                words_in++;
                if (load_last || words_in == 64) phase = PH_HANDOFF;
            end
        end else if (phase == PH_HANDOFF) begin
            phase = PH_RUNNING;
        end else if (write_in && writable(address_in)) begin
            m_data[address_in] = data_in;
        end
        m_kbd = rst ? 16'h0 : keyboard_in;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Compares data_out with the model wherever the model knows the value.
    task automatic chk_read(input string tag);
        if (address_in == 16'h6000)
            chk(tag, data_out, m_kbd);
        else if (!writable(address_in))
            chk(tag, data_out, 16'h0000);
        else if (m_data.exists(address_in))
            chk(tag, data_out, m_data[address_in]);
    endtask

    task automatic chk_phase(input string tag);
        chk({tag, "_ready"},  {15'b0, load_ready},  {15'b0, phase == PH_LOADING});
        chk({tag, "_cpurst"}, {15'b0, cpu_rst_out}, {15'b0, phase != PH_RUNNING});
    endtask

    initial begin
        prog1 = '{16'h0002, 16'hEC10, 16'h0003, 16'hE088, 16'h0000, 16'hE310};
        rst = 1'b1; pc_in = '0; address_in = '0; write_in = 1'b0; data_in = '0;
        keyboard_in = 16'h1234; load_valid = 1'b0; load_data = '0; load_last = 1'b0;

        // ---- reset state
        tick(); tick();
        chk("rst_load_ready", {15'b0, load_ready}, 16'h0001);
        chk("rst_cpu_rst", {15'b0, cpu_rst_out}, 16'h0001);
        address_in = 16'h6000; #1;
        chk("rst_kbd", data_out, 16'h0000);
        rst = 1'b0;

        // ---- 1: stream six words, last on the sixth
        for (int i = 0; i < 6; i++) begin
            load_valid = 1'b1; load_data = prog1[i]; load_last = (i == 5);
            pc_in = 16'($urandom_range(0, 63)); #1;
            chk("load_ready_hi", {15'b0, load_ready}, 16'h0001);
            chk("instr_zero_load", instruction_out, 16'h0000);
            tick();
        end
        load_valid = 1'b0; load_last = 1'b0; pc_in = 16'h0003; #1;
        chk("release_ready", {15'b0, load_ready}, 16'h0000);
        chk("release_cpu_rst", {15'b0, cpu_rst_out}, 16'h0001);
        chk("release_instr", instruction_out, 16'h0000);
        tick();
        chk("run_cpu_rst", {15'b0, cpu_rst_out}, 16'h0000);
        chk("run_instr3", instruction_out, 16'hE088);
        for (int p = 0; p < 6; p++) begin
            pc_in = 16'(p); #1;
            chk("prog1_rom", instruction_out, m_rom[p]);
        end

        // ---- 2: RAM write, read-old-then-new, keyboard write dropped
        address_in = 16'h0005; write_in = 1'b1; data_in = 16'h1111; tick();
        data_in = 16'hABCD; #1;
        chk("same_cycle_old", data_out, 16'h1111);
        tick();
        write_in = 1'b0; #1;
        chk("ram_5_new", data_out, 16'hABCD);
        address_in = 16'h6000; write_in = 1'b1; data_in = 16'hBEEF; tick();
        write_in = 1'b0; #1;
        chk("kbd_write_dropped", data_out, 16'h1234);

        // ---- 3: keyboard latency and unmapped read
        keyboard_in = 16'h0041; #1;
        chk("kbd_before_edge", data_out, 16'h1234);
        tick();
        chk("kbd_after_edge", data_out, 16'h0041);
        address_in = 16'h7FFF; #1;
        chk("unmapped_7fff", data_out, 16'h0000);

        // ---- 4: screen write does not alias RAM
        address_in = 16'h0010; write_in = 1'b1; data_in = 16'h5A5A; tick();
        address_in = 16'h4010; data_in = 16'h1234; tick();
        write_in = 1'b0; #1;
        chk("screen_4010", data_out, 16'h1234);
        address_in = 16'h0010; #1;
        chk("ram_0010_kept", data_out, 16'h5A5A);

        // ---- randomised traffic around the region boundaries
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: address_in = 16'($urandom_range(0, 15));
                1: address_in = 16'h3FF8 + 16'($urandom_range(0, 7));
                2: address_in = 16'h4000 + 16'($urandom_range(0, 7));
                3: address_in = 16'h40F8 + 16'($urandom_range(0, 7));
                4: address_in = 16'h6000;
                default: address_in = ($urandom_range(0, 1) == 1) ?
                                      16'($urandom_range(16'h4100, 16'h5FFF)) :
                                      16'($urandom_range(16'h6001, 16'hFFFF));
            endcase
            write_in    = ($urandom_range(0, 1) == 1);
            data_in     = 16'($urandom);
            keyboard_in = 16'($urandom);
            #1;
            chk_read("rand_read");
            tick();
        end
        write_in = 1'b0;

        // ---- 5: reset mid-load, reload two words; LOAD-phase writes ignored
        rst = 1'b1; tick(); rst = 1'b0;
        address_in = 16'h0005; write_in = 1'b1; data_in = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = 16'($urandom); load_last = 1'b0; tick();
        end
        w2 = m_rom[2];
        rst = 1'b1; load_valid = 1'b0; tick(); rst = 1'b0;
        chk_phase("midload_rst");
        w0 = 16'($urandom); w1 = 16'($urandom);
        load_valid = 1'b1; load_data = w0; tick();
        load_data = w1; load_last = 1'b1; tick();
        load_valid = 1'b0; load_last = 1'b0; tick();
        write_in = 1'b0; #1;
        chk_phase("reload_run");
        chk_read("load_write_ignored");
        pc_in = 16'h0000; #1; chk("reload_rom0", instruction_out, w0);
        pc_in = 16'h0001; #1; chk("reload_rom1", instruction_out, w1);
        pc_in = 16'h0002; #1; chk("partial_rom2", instruction_out, w2);
        pc_in = 16'h0040; #1; chk("pc_out_of_rom", instruction_out, 16'h0000);

        // ---- 6: full-depth load without load_last
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            load_valid = 1'b1; load_data = 16'($urandom); load_last = 1'b0; #1;
            chk("full_ready", {15'b0, load_ready}, 16'h0001);
            tick();
        end
        load_data = 16'hDEAD; #1;
        chk("word65_ready", {15'b0, load_ready}, 16'h0000);
        chk("word65_cpu_rst", {15'b0, cpu_rst_out}, 16'h0001);
        tick();
        load_valid = 1'b0; #1;
        chk_phase("full_run");
        for (int p = 0; p < 64; p++) begin
            pc_in = 16'(p); #1;
            chk("full_rom", instruction_out, m_rom[p]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
